// File: rtl/bitonic_sort8_stream.sv
// Streaming 8-element bitonic sorter.
// Accepts 8 words serially, sorts them in place with the 6-stage bitonic
// compare-exchange schedule (one stage per clock), then streams them out.
// Optional feature macro: BITONIC_SORT8_FLUSH_EN adds a synchronous 'flush' input.
module bitonic_sort8_stream #(
    parameter int DW  = 8,
    parameter int DIR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef BITONIC_SORT8_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    typedef enum logic [1:0] {LOAD, SORT, UNLOAD} state_t;

    state_t        state;
    state_t        next_state;
    logic [DW-1:0] data_buf [8];
    logic [DW-1:0] sorted   [8];
    logic [2:0]    wr_idx;
    logic [2:0]    stage;
    logic [2:0]    rd_idx;
    logic [3:0]    stg_k;
    logic [2:0]    stg_j;
    logic          flush_req;

`ifdef BITONIC_SORT8_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Map the stage counter onto the (k, j) parameters of the bitonic schedule
    always_comb begin
        stg_k = 4'd2;
        stg_j = 3'd1;
        case (stage)
            3'd0: begin stg_k = 4'd2; stg_j = 3'd1; end
            3'd1: begin stg_k = 4'd4; stg_j = 3'd2; end
            3'd2: begin stg_k = 4'd4; stg_j = 3'd1; end
            3'd3: begin stg_k = 4'd8; stg_j = 3'd4; end
            3'd4: begin stg_k = 4'd8; stg_j = 3'd2; end
            3'd5: begin stg_k = 4'd8; stg_j = 3'd1; end
            default: begin stg_k = 4'd2; stg_j = 3'd1; end
        endcase
    end

    // Apply all four compare-exchanges of the current stage in parallel
    always_comb begin
        logic [2:0] ii;
        logic [2:0] pp;
        logic       asc;
        ii  = 3'd0;
        pp  = 3'd0;
        asc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sorted[i] = data_buf[i];
        end
        for (int i = 0; i < 8; i++) begin
            ii = 3'(i);
            pp = ii ^ stg_j;
            if (pp > ii) begin
                asc = ((({1'b0, ii} & stg_k) == 4'd0) != (DIR != 0));
                if (asc ? (data_buf[ii] > data_buf[pp]) : (data_buf[ii] < data_buf[pp])) begin
                    sorted[ii] = data_buf[pp];
                    sorted[pp] = data_buf[ii];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and handshake/status outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        busy       = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (wr_idx == 3'd7)) begin
                    next_state = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (stage == 3'd5) begin
                    next_state = UNLOAD;
                end
            end
            UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = data_buf[rd_idx];
                out_last  = (rd_idx == 3'd7);
                if (out_ready && (rd_idx == 3'd7)) begin
                    next_state = LOAD;
                end
            end
            default: next_state = LOAD;
        endcase
        if (flush_req) begin
            next_state = LOAD;
        end
    end

    // Buffer and index counters; flush wins over any handshake in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                data_buf[i] <= '0;
            end
            wr_idx <= 3'd0;
            stage  <= 3'd0;
            rd_idx <= 3'd0;
        end else if (flush_req) begin
            wr_idx <= 3'd0;
            stage  <= 3'd0;
            rd_idx <= 3'd0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        data_buf[wr_idx] <= in_data;
                        wr_idx           <= wr_idx + 3'd1;
                        stage            <= 3'd0;
                    end
                end
                SORT: begin
                    for (int i = 0; i < 8; i++) begin
                        data_buf[i] <= sorted[i];
                    end
                    if (stage == 3'd5) begin
                        stage  <= 3'd0;
                        rd_idx <= 3'd0;
                    end else begin
                        stage <= stage + 3'd1;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        rd_idx <= rd_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitonic_sort8_stream.sv
// Self-checking bench for bitonic_sort8_stream: an ascending (DIR=0) and a
// descending (DIR=1) instance share all inputs; their outputs are compared
// against a plain sort of each loaded block.
module tb_bitonic_sort8_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       flush;

    logic       in_ready_a, out_valid_a, out_last_a, busy_a;
    logic [7:0] out_data_a;
    logic       in_ready_d, out_valid_d, out_last_d, busy_d;
    logic [7:0] out_data_d;

    int pass_count;
    int check_count;

    logic [7:0] cur_in   [8];
    logic [7:0] exp_asc  [8];
    logic [7:0] exp_desc [8];

    bitonic_sort8_stream #(.DW(8), .DIR(0)) dut_asc (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef BITONIC_SORT8_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_data   (in_data),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_data  (out_data_a),
        .out_last  (out_last_a),
        .busy      (busy_a)
    );

    bitonic_sort8_stream #(.DW(8), .DIR(1)) dut_desc (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef BITONIC_SORT8_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready_d),
        .in_data   (in_data),
        .out_valid (out_valid_d),
        .out_ready (out_ready),
        .out_data  (out_data_d),
        .out_last  (out_last_d),
        .busy      (busy_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end else begin
            pass_count++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain sort of the loaded block
    task automatic computeExpected();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) exp_asc[i] = cur_in[i];
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 7 - i; j++) begin
                if (exp_asc[j] > exp_asc[j+1]) begin
                    t = exp_asc[j];
                    exp_asc[j] = exp_asc[j+1];
                    exp_asc[j+1] = t;
                end
            end
        end
        for (int i = 0; i < 8; i++) exp_desc[i] = exp_asc[7-i];
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".in_ready_a"}, in_ready_a, 1);
        checkOutput({tag, ".in_ready_d"}, in_ready_d, 1);
        checkOutput({tag, ".out_valid_a"}, out_valid_a, 0);
        checkOutput({tag, ".out_valid_d"}, out_valid_d, 0);
        checkOutput({tag, ".busy_a"}, busy_a, 0);
        checkOutput({tag, ".busy_d"}, busy_d, 0);
        checkOutput({tag, ".out_data_a"}, out_data_a, 0);
        checkOutput({tag, ".out_last_a"}, out_last_a, 0);
    endtask

    // Feed the first n words of cur_in, one per cycle with in_valid held high
    task automatic loadWords(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = cur_in[i];
            checkOutput("load.in_ready_a", in_ready_a, 1);
            checkOutput("load.in_ready_d", in_ready_d, 1);
            step();
        end
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
    endtask

    task automatic applyStimulus();
        computeExpected();
        loadWords(8);
        checkOutput("sort.busy_a", busy_a, 1);
        checkOutput("sort.in_ready_a", in_ready_a, 0);
        checkOutput("sort.out_valid_a", out_valid_a, 0);
    endtask

    function automatic logic readyFor(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return logic'($urandom_range(0, 1));
    endfunction

    // Wait for the sorted block and drain it; mode selects the out_ready pattern
    task automatic drainBlock(input int mode);
        int wait_cycles;
        int n;
        int cyc;
        wait_cycles = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (!out_valid_a && wait_cycles < 20) begin
            checkOutput("sort.busy_hold", busy_a, 1);
            checkOutput("sort.in_stall", in_ready_a, 0);
            step();
            wait_cycles++;
        end
        in_valid = 1'b0;
        checkOutput("latency", wait_cycles, 6);
        n = 0;
        cyc = 0;
        while (n < 8 && cyc < 100) begin
            out_ready = readyFor(mode, cyc);
            checkOutput("unload.valid_a", out_valid_a, 1);
            checkOutput("unload.valid_d", out_valid_d, 1);
            checkOutput("unload.data_a", out_data_a, exp_asc[n]);
            checkOutput("unload.data_d", out_data_d, exp_desc[n]);
            checkOutput("unload.last_a", out_last_a, (n == 7) ? 1 : 0);
            checkOutput("unload.last_d", out_last_d, (n == 7) ? 1 : 0);
            checkOutput("unload.in_ready", in_ready_a, 0);
            checkOutput("unload.busy", busy_a, 1);
            if (out_ready) n++;
            step();
            cyc++;
        end
        checkOutput("unload.count", n, 8);
        out_ready = 1'b0;
        checkIdle("after_unload");
    endtask

    task automatic setBlock(input logic [63:0] packed_vals);
        for (int i = 0; i < 8; i++) cur_in[i] = packed_vals[63 - 8*i -: 8];
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #12;
        checkIdle("reset");
        checkOutput("reset.out_last_d", out_last_d, 0);
        rst_n = 1'b1;
        step();

        $display("[TB] descending input block");
        setBlock({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        applyStimulus();
        drainBlock(0);

        $display("[TB] duplicates and extremes");
        setBlock({8'd5, 8'd3, 8'd5, 8'd0, 8'd255, 8'd3, 8'd1, 8'd5});
        applyStimulus();
        drainBlock(0);

        $display("[TB] ascending input block");
        setBlock({8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7});
        applyStimulus();
        drainBlock(0);

        $display("[TB] backpressure");
        setBlock({8'd42, 8'd17, 8'd99, 8'd3, 8'd200, 8'd17, 8'd64, 8'd128});
        applyStimulus();
        drainBlock(1);

        $display("[TB] reset mid-sort");
        setBlock({8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88});
        applyStimulus();
        step();
        step();
        step();
        checkOutput("midsort.busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        checkIdle("midsort_reset");
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checkOutput("post_reset.out_valid", out_valid_a | out_valid_d, 0);
            step();
        end
        setBlock({8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4});
        applyStimulus();
        drainBlock(0);

        $display("[TB] randomized blocks");
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < 8; i++) begin
                cur_in[i] = (b % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            end
            applyStimulus();
            drainBlock(2);
        end

`ifdef BITONIC_SORT8_FLUSH_EN
        $display("[TB] flush during load");
        setBlock({8'd250, 8'd240, 8'd230, 8'd220, 8'd210, 8'd0, 8'd0, 8'd0});
        loadWords(5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkIdle("flush_load");
        setBlock({8'd13, 8'd200, 8'd7, 8'd99, 8'd7, 8'd45, 8'd150, 8'd2});
        applyStimulus();
        drainBlock(0);

        $display("[TB] flush during unload");
        setBlock({8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd5, 8'd1});
        applyStimulus();
        for (int c = 0; c < 6; c++) step();
        computeExpected();
        out_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            checkOutput("flush_unload.data", out_data_a, exp_asc[n]);
            step();
        end
        flush = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        checkIdle("flush_unload");
        for (int c = 0; c < 8; c++) begin
            checkOutput("flush_unload.no_valid", out_valid_a, 0);
            step();
        end
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
